pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use and branch-operand hazards in ID and squashes the wrong-path fetch on taken branches and jumps. It also sequences the iterative mul/div unit by stalling the front end for a fixed number of cycles. Its outputs drive the PC enable, the IF/ID write and flush controls, and the ID/EX register's synchronous `reset` bubble input.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
//   hz_state_e : hazard sequencer states (RUN, MD_WAIT)
//   reg_idx_t  : 5-bit architectural register index
//   REG_ZERO   : index of $zero, never a real dependency
//   reg_match  : source-vs-destination dependency compare
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // True when the ID instruction reads 'dst' (rs always, rt only when used).
    // Writes to $zero are discarded by the register file, so they never match.
    function automatic logic reg_match(input reg_idx_t rs,
                                       input reg_idx_t rt,
                                       input logic     uses_rt,
                                       input reg_idx_t dst);
        return (dst != REG_ZERO) && ((rs == dst) || (uses_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational dependency check for the instruction in ID.
// Ports:
//   id_rs, id_rt, id_uses_rt : ID source registers and rt-usage flag
//   id_branch                : ID instruction is a conditional branch
//   ex_memread, ex_regwrite  : ID/EX control bits
//   ex_wr_reg                : EX destination register
//   mem_memread, mem_wr_reg  : EX/MEM load flag and destination register
//   lu_haz                   : load-use hazard against the load in EX
//   br_haz                   : branch operand not yet available in ID
// -----------------------------------------------------------------------------
module hazard_detect
    import pipeline_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rt,
    input  logic     id_branch,
    input  logic     ex_memread,
    input  logic     ex_regwrite,
    input  reg_idx_t ex_wr_reg,
    input  logic     mem_memread,
    input  reg_idx_t mem_wr_reg,
    output logic     lu_haz,
    output logic     br_haz
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(id_rs, id_rt, id_uses_rt, ex_wr_reg);
    assign mem_match = reg_match(id_rs, id_rt, id_uses_rt, mem_wr_reg);

    assign lu_haz = ex_memread & ex_match;

    // Branches compare in ID, so any producer still in EX blocks them, and a
    // load in MEM has not yet returned its data to forward.
    assign br_haz = id_branch & ((ex_regwrite & ex_match) | (mem_memread & mem_match));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer: stalls on load-use and branch-operand
// hazards, squashes the wrong-path fetch on taken branches/jumps and freezes
// the front end while the iterative mul/div unit runs.
// Parameters:
//   MULDIV_CYCLES : front-end stall cycles after a mul/div issue (1..255)
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   id_*                           : ID instruction sources and class flags
//   ex_memread, ex_regwrite,
//   ex_wr_reg                      : ID/EX control and destination
//   mem_memread, mem_wr_reg        : EX/MEM load flag and destination
//   pc_write, if_id_write          : PC / IF/ID load enables
//   if_id_flush                    : zero IF/ID on the next edge
//   id_ex_flush                    : ID/EX bubble (drives its reset)
//   muldiv_start                   : one-cycle issue pulse to mul/div unit
//   md_busy                        : high while waiting on mul/div
//   stall_cycles, flush_count      : wrapping performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  reg_idx_t    id_rs,
    input  reg_idx_t    id_rt,
    input  logic        id_uses_rt,
    input  logic        id_branch,
    input  logic        id_branch_taken,
    input  logic        id_jump,
    input  logic        id_muldiv,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  reg_idx_t    ex_wr_reg,
    input  logic        mem_memread,
    input  reg_idx_t    mem_wr_reg,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        muldiv_start,
    output logic        md_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [7:0] MD_CNT_INIT = 8'(MULDIV_CYCLES);

    hz_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] stall_q, flush_q;

    logic lu_haz;
    logic br_haz;
    logic haz;

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_wr_reg   (ex_wr_reg),
        .mem_memread (mem_memread),
        .mem_wr_reg  (mem_wr_reg),
        .lu_haz      (lu_haz),
        .br_haz      (br_haz)
    );

    assign haz = lu_haz | br_haz;

    // Control outputs are combinational so the stall/flush takes effect in
    // the same cycle the hazard is seen in ID.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        muldiv_start = 1'b0;
        md_busy      = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (haz) begin
                        // Hold PC and IF/ID, bubble into EX; branch/jump/muldiv
                        // re-evaluate once the operand is available.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        if (id_branch_taken || id_jump) begin
                            if_id_flush = 1'b1;
                        end
                        if (id_muldiv) begin
                            muldiv_start = 1'b1;
                            cnt_d        = MD_CNT_INIT;
                            state_d      = MD_WAIT;
                        end
                    end
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    md_busy     = 1'b1;
                    cnt_d       = cnt_q - 8'd1;
                    // <=1 also recovers from a zero count rather than wrapping
                    // into a 255-cycle wait.
                    if (cnt_q <= 8'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
